ri_ro_mixer_scheduler: RTL and testbench

Time-multiplexes one shared real-in/real-out mixer datapath (16-bit signed multiply, round, saturate; 3-cycle registered latency) among NCH requesting channels. A round-robin arbiter accepts at most one operand pair per cycle over valid/ready handshakes, drives the mixer operands, and tags each issue with its channel. Each result is returned with its channel index when it leaves the mixer. The block sits between the per-channel DDC/DUC front ends and a single mixer instance, so the mixer's DSP resources are shared.

---
 rtl/ri_ro_mixer_scheduler.sv | 126 ++++++++++++
 tb/tb_ri_ro_mixer_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ri_ro_mixer_scheduler.sv
// Round-robin scheduler that shares one real-in/real-out mixer among NCH channels.
// Grants one operand pair per cycle, tags it, and returns the mixer result with its channel.
module ri_ro_mixer_scheduler #(
  parameter int NCH     = 4,
  parameter int DSZ     = 16,
  parameter int MIX_LAT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [NCH-1:0]           req_valid,
  input  logic [NCH*DSZ-1:0]       req_in,
  input  logic [NCH*DSZ-1:0]       req_lo,
  output logic [NCH-1:0]           req_ready,
  output logic [DSZ-1:0]           mix_in,
  output logic [DSZ-1:0]           mix_lo,
  input  logic [DSZ-1:0]           mix_out,
  output logic                     res_valid,
  output logic [$clog2(NCH)-1:0]   res_ch,
  output logic [DSZ-1:0]           res_data,
  output logic                     busy
);
  localparam int CW = $clog2(NCH);
  localparam int NT = MIX_LAT + 1;

  logic [CW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  grant_idx;
  logic           grant_found;
  logic [CW:0]    idx_w;
  logic [CW:0]    ptr_inc;
  logic           xfer;
  logic [DSZ-1:0] mix_in_q, mix_in_d;
  logic [DSZ-1:0] mix_lo_q, mix_lo_d;
  logic [NT-1:0]  tag_v_q, tag_v_d;
  logic [CW-1:0]  tag_ch_q [NT];
  logic [CW-1:0]  tag_ch_d [NT];
  logic           res_valid_q, res_valid_d;
  logic [CW-1:0]  res_ch_q, res_ch_d;
  logic [DSZ-1:0] res_data_q, res_data_d;

  // Search ptr, ptr+1, ... with wrap; first valid channel wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_w       = '0;
    for (int k = 0; k < NCH; k++) begin
      idx_w = {1'b0, ptr_q} + (CW+1)'(k);
      if (idx_w >= (CW+1)'(NCH)) begin
        idx_w = idx_w - (CW+1)'(NCH);
      end
      if (!grant_found && req_valid[idx_w[CW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx_w[CW-1:0];
      end
    end
    if (!en) begin
      grant_found = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign xfer = |(req_valid & req_ready);

  always_comb begin
    ptr_d    = ptr_q;
    ptr_inc  = {1'b0, grant_idx} + (CW+1)'(1);
    mix_in_d = '0;
    mix_lo_d = '0;
    if (xfer) begin
      ptr_d    = (ptr_inc == (CW+1)'(NCH)) ? '0 : ptr_inc[CW-1:0];
      mix_in_d = req_in[grant_idx*DSZ +: DSZ];
      mix_lo_d = req_lo[grant_idx*DSZ +: DSZ];
    end

    // Tags walk alongside the mixer pipeline so the last stage lines up with mix_out.
    tag_v_d     = {tag_v_q[NT-2:0], xfer};
    tag_ch_d[0] = xfer ? grant_idx : '0;
    for (int s = 1; s < NT; s++) begin
      tag_ch_d[s] = tag_ch_q[s-1];
    end

    res_valid_d = tag_v_q[NT-1];
    res_ch_d    = tag_ch_q[NT-1];
    res_data_d  = tag_v_q[NT-1] ? mix_out : res_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      mix_in_q    <= '0;
      mix_lo_q    <= '0;
      tag_v_q     <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_data_q  <= '0;
      for (int s = 0; s < NT; s++) begin
        tag_ch_q[s] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      mix_in_q    <= mix_in_d;
      mix_lo_q    <= mix_lo_d;
      tag_v_q     <= tag_v_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_data_q  <= res_data_d;
      for (int s = 0; s < NT; s++) begin
        tag_ch_q[s] <= tag_ch_d[s];
      end
    end
  end

  assign mix_in    = mix_in_q;
  assign mix_lo    = mix_lo_q;
  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_data  = res_data_q;
  assign busy      = (|tag_v_q) | res_valid_q;

endmodule

// File: tb/tb_ri_ro_mixer_scheduler.sv
// Bench for ri_ro_mixer_scheduler: a behavioural mixer, a queue-based result model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_ri_ro_mixer_scheduler;
  localparam int NCH     = 4;
  localparam int DSZ     = 16;
  localparam int MIX_LAT = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 en;
  logic [NCH-1:0]       req_valid;
  logic [NCH*DSZ-1:0]   req_in;
  logic [NCH*DSZ-1:0]   req_lo;
  logic [NCH-1:0]       req_ready;
  logic [DSZ-1:0]       mix_in;
  logic [DSZ-1:0]       mix_lo;
  logic [DSZ-1:0]       mix_out;
  logic                 res_valid;
  logic [1:0]           res_ch;
  logic [DSZ-1:0]       res_data;
  logic                 busy;

  logic signed [DSZ-1:0] in_a [NCH];
  logic signed [DSZ-1:0] lo_a [NCH];

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;
  int edge_n = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_in = '0;
    req_lo = '0;
    for (int i = 0; i < NCH; i++) begin
      req_in[i*DSZ +: DSZ] = in_a[i];
      req_lo[i*DSZ +: DSZ] = lo_a[i];
    end
  end

  ri_ro_mixer_scheduler #(.NCH(NCH), .DSZ(DSZ), .MIX_LAT(MIX_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req_valid (req_valid),
    .req_in    (req_in),
    .req_lo    (req_lo),
    .req_ready (req_ready),
    .mix_in    (mix_in),
    .mix_lo    (mix_lo),
    .mix_out   (mix_out),
    .res_valid (res_valid),
    .res_ch    (res_ch),
    .res_data  (res_data),
    .busy      (busy)
  );

  // Q15 multiply, round half up, saturate to 16 bits.
  function automatic logic signed [15:0] mixfn(input logic signed [15:0] a, input logic signed [15:0] b);
    longint p;
    p = (longint'(a) * longint'(b) + 64'sd16384) >>> 15;
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
    return 16'(p);
  endfunction

  logic signed [15:0] mpipe [MIX_LAT];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MIX_LAT; i++) mpipe[i] <= '0;
    end else begin
      mpipe[0] <= mixfn($signed(mix_in), $signed(mix_lo));
      for (int i = 1; i < MIX_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mix_out = mpipe[MIX_LAT-1];

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Result model: each accepted pair becomes an entry due MIX_LAT+2 edges after the check point.
  typedef struct { int due; int ch; int data; } res_t;
  res_t q[$];
  int m_ptr  = 0;
  int m_in   = 0;
  int m_lo   = 0;
  int m_data = 0;

  always @(negedge clk) begin : model
    int g;
    int idx;
    int e_valid;
    int e_ch;
    int e_busy;
    int e_ready;
    while (q.size() > 0 && q[0].due < edge_n) void'(q.pop_front());
    e_valid = (q.size() > 0 && q[0].due == edge_n) ? 1 : 0;
    e_ch = 0;
    if (e_valid == 1) begin
      e_ch   = q[0].ch;
      m_data = q[0].data;
    end
    e_busy = (q.size() > 0) ? 1 : 0;
    g = -1;
    if (en) begin
      for (int k = 0; k < NCH; k++) begin
        idx = (m_ptr + k) % NCH;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    e_ready = (g >= 0) ? (1 << g) : 0;
    if (chk_on) begin
      chk("m_res_valid", int'(res_valid), e_valid);
      if (e_valid == 1) chk("m_res_ch", int'(res_ch), e_ch);
      chk("m_res_data", int'($signed(res_data)), m_data);
      chk("m_busy", int'(busy), e_busy);
      chk("m_mix_in", int'($signed(mix_in)), m_in);
      chk("m_mix_lo", int'($signed(mix_lo)), m_lo);
      chk("m_ready", int'(req_ready), e_ready);
    end
    if (reset) begin
      q.delete();
      m_ptr  = 0;
      m_in   = 0;
      m_lo   = 0;
      m_data = 0;
    end else if (g >= 0) begin
      q.push_back('{edge_n + MIX_LAT + 2, g, int'(mixfn(in_a[g], lo_a[g]))});
      m_ptr = (g + 1) % NCH;
      m_in  = in_a[g];
      m_lo  = lo_a[g];
    end else begin
      m_in = 0;
      m_lo = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input int ch, input int a, input int b, input int exp_d, input string nm);
    int lat;
    req_valid = '0;
    req_valid[ch] = 1'b1;
    in_a[ch] = 16'(a);
    lo_a[ch] = 16'(b);
    #1 chk({nm, "_grant"}, int'(req_ready), 1 << ch);
    step();
    req_valid = '0;
    lat = 0;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (res_valid && lat == 0) begin
        lat = e;
        chk({nm, "_ch"}, int'(res_ch), ch);
        chk({nm, "_data"}, int'($signed(res_data)), exp_d);
        chk({nm, "_busy_hi"}, int'(busy), 1);
      end else if (lat != 0 && e == lat + 1) begin
        chk({nm, "_busy_lo"}, int'(busy), 0);
        chk({nm, "_strobe_1cyc"}, int'(res_valid), 0);
      end
    end
    chk({nm, "_latency"}, lat, 4);
  endtask

  initial begin : stim
    int got[$];
    int first_c;
    int last_c;
    int cnt;
    reset = 1'b1;
    en = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NCH; i++) begin
      in_a[i] = '0;
      lo_a[i] = '0;
    end
    repeat (3) step();
    reset = 1'b0;
    chk_on = 1'b1;
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_mix_in", int'(mix_in), 0);

    issue_one(2, 16384, 16384, 8192, "single");
    issue_one(0, -32768, -32768, 32767, "sat_pos");
    issue_one(0, -32768, 32767, -32767, "sat_neg");

    // Fairness from a fresh pointer.
    reset = 1'b1;
    step();
    reset = 1'b0;
    first_c = -1;
    last_c = -1;
    for (int c = 0; c < 20; c++) begin
      if (c < 12) begin
        req_valid = '1;
        for (int i = 0; i < NCH; i++) begin
          in_a[i] = 16'(i + 1);
          lo_a[i] = 16'sd32767;
        end
        #1 chk("fair_grant", int'(req_ready), 1 << (c % 4));
      end else begin
        req_valid = '0;
      end
      step();
      if (res_valid) begin
        got.push_back(int'(res_ch));
        if (first_c < 0) first_c = c;
        last_c = c;
      end
    end
    chk("fair_count", got.size(), 12);
    chk("fair_span", last_c - first_c, 11);
    for (int k = 0; k < got.size(); k++) chk("fair_res_ch", got[k], k % 4);

    // Wrap and skip.
    issue_one(2, 100, 200, 1, "pre_wrap");
    req_valid = 4'b1010;
    #1 chk("wrap_g3", int'(req_ready), 8);
    step();
    #1 chk("wrap_g1", int'(req_ready), 2);
    step();
    req_valid = 4'b0110;
    #1 chk("wrap_ptr2", int'(req_ready), 4);
    req_valid = '0;
    step();
    req_valid = 4'b0110;
    #1 chk("drop_hold", int'(req_ready), 4);
    req_valid = '0;
    repeat (6) step();

    // Enable and drain.
    req_valid = '1;
    repeat (3) step();
    en = 1'b0;
    #1 chk("en_ready", int'(req_ready), 0);
    chk("en_busy", int'(busy), 1);
    cnt = 0;
    for (int e = 0; e < 8; e++) begin
      step();
      if (res_valid) cnt++;
    end
    chk("drain_count", cnt, 3);
    chk("drain_busy", int'(busy), 0);
    req_valid = '0;
    en = 1'b1;

    // Reset two edges after a transfer.
    in_a[1] = 16'sd1000;
    lo_a[1] = 16'sd1000;
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_res_valid", int'(res_valid), 0);
    chk("mrst_res_data", int'(res_data), 0);
    chk("mrst_res_ch", int'(res_ch), 0);
    chk("mrst_mix_in", int'(mix_in), 0);
    chk("mrst_mix_lo", int'(mix_lo), 0);
    chk("mrst_busy", int'(busy), 0);
    cnt = 0;
    for (int e = 0; e < 6; e++) begin
      step();
      if (res_valid) cnt++;
    end
    chk("mrst_no_result", cnt, 0);
    req_valid = 4'b1010;
    #1 chk("mrst_first_grant", int'(req_ready), 2);
    step();
    req_valid = '0;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
